// File: rtl/request_encoder_8_to_3.sv
// request_encoder_8_to_3
//   Registered 8-to-3 request encoder feeding the register-file write-select
//   decoder. Picks one of eight request lines and presents its index and
//   one-hot vector on a valid/ready output stage.
//
//   Configuration macro: REQ_ENC_ROUND_ROBIN_EN
//     defined   -> rotating priority; the pointer moves past each accepted grant
//     undefined -> fixed priority, bit 0 highest
//
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   enable        in   0 blocks new grants; a held grant is still presented
//   request[7:0]  in   request lines, multi-hot allowed
//   grant_ready   in   consumer accepts the presented grant this cycle
//   grant_valid   out  grant_index / grant_onehot are valid
//   grant_index   out  encoded index of the granted requester
//   grant_onehot  out  one-hot of grant_index while valid, else 0
module request_encoder_8_to_3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] request,
    input  logic       grant_ready,
    output logic       grant_valid,
    output logic [2:0] grant_index,
    output logic [7:0] grant_onehot
);

    logic       accept;
    logic       load;
    logic [2:0] scan_base;
    logic [2:0] winner;
    logic       found;

    assign accept = grant_valid & grant_ready;
    assign load   = enable & (|request) & (~grant_valid | grant_ready);

`ifdef REQ_ENC_ROUND_ROBIN_EN
    logic [2:0] ptr;

    // On a same-cycle accept the scan must already start past the grant
    // being retired, so bypass the pointer register with its next value.
    assign scan_base = accept ? grant_index + 3'd1 : ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 3'd0;
        end else if (accept) begin
            ptr <= grant_index + 3'd1;
        end
    end
`else
    assign scan_base = 3'd0;
`endif

    // First set bit scanning scan_base, scan_base+1, ... with 3-bit wrap.
    always_comb begin
        winner = 3'd0;
        found  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!found && request[scan_base + 3'(k)]) begin
                winner = scan_base + 3'(k);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_valid  <= 1'b0;
            grant_index  <= 3'd0;
            grant_onehot <= 8'd0;
        end else if (load) begin
            grant_valid  <= 1'b1;
            grant_index  <= winner;
            grant_onehot <= 8'b1 << winner;
        end else if (accept) begin
            // Index is held on drain; only valid and the one-hot clear.
            grant_valid  <= 1'b0;
            grant_onehot <= 8'd0;
        end
    end

endmodule
